// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/HI-LO control stage: op encodings, FSM states, word width.
package mdu_pkg;

    localparam int WORD = 32;

    typedef enum logic [2:0] {
        MDU_NONE = 3'd0,
        MULT     = 3'd1,
        MULTU    = 3'd2,
        MTHI     = 3'd3,
        MTLO     = 3'd4,
        MFHI     = 3'd5,
        MFLO     = 3'd6
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

    localparam logic [WORD-1:0] WORD_ONE = 1;

    // Two's-complement magnitude; 0x80000000 stays 0x80000000, which is its unsigned magnitude.
    function automatic logic [WORD-1:0] abs_word(input logic [WORD-1:0] v);
        return v[WORD-1] ? (~v + WORD_ONE) : v;
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling around the unsigned multiplier: operand magnitudes and result sign on the way
// in, conditional 64-bit negation of the product on the way out.
module mdu_sign_fix
    import mdu_pkg::*;
(
    input  logic [WORD-1:0]   rs_val,
    input  logic [WORD-1:0]   rt_val,
    input  logic              is_signed,
    input  logic              neg,
    input  logic [2*WORD-1:0] prod,
    output logic [WORD-1:0]   abs_a,
    output logic [WORD-1:0]   abs_b,
    output logic              neg_o,
    output logic [2*WORD-1:0] prod_fix
);

    localparam logic [2*WORD-1:0] DWORD_ONE = 1;

    assign abs_a    = is_signed ? abs_word(rs_val) : rs_val;
    assign abs_b    = is_signed ? abs_word(rt_val) : rt_val;
    assign neg_o    = is_signed & (rs_val[WORD-1] ^ rt_val[WORD-1]);
    assign prod_fix = neg ? (~prod + DWORD_ONE) : prod;

endmodule

// File: rtl/hilo_unit.sv
// EX-stage HI/LO control: launches the sequential multiplier, holds the pipeline while a product
// is outstanding, commits the sign-corrected product and serves MFHI/MFLO.
module hilo_unit
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [WORD-1:0]   rs_val,
    input  logic [WORD-1:0]   rt_val,
    input  logic              ext_stall,
    output logic              stall_req,
    output logic [WORD-1:0]   mf_data,
    output logic [WORD-1:0]   hi,
    output logic [WORD-1:0]   lo,
    output logic              mul_start,
    output logic [WORD-1:0]   mul_a,
    output logic [WORD-1:0]   mul_b,
    output logic              mul_cpu_stall,
    input  logic [2*WORD-1:0] mul_z,
    input  logic              mul_busy,
    input  logic              mul_finish
);

    mdu_state_e        state_q, state_d;
    logic [WORD-1:0]   hi_q, hi_d;
    logic [WORD-1:0]   lo_q, lo_d;
    logic              neg_q, neg_d;

    logic              op_live;
    logic              busy_stall;
    logic              accept;
    logic              start;
    logic [WORD-1:0]   mf_sel;
    logic [WORD-1:0]   abs_a, abs_b;
    logic              neg_calc;
    logic [2*WORD-1:0] prod_fix;

    // Our own FSM already tracks the multiplier's busy period.
    logic unused_ok;
    assign unused_ok = mul_busy;

    mdu_sign_fix u_sign_fix (
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .is_signed (op == MULT),
        .neg       (neg_q),
        .prod      (mul_z),
        .abs_a     (abs_a),
        .abs_b     (abs_b),
        .neg_o     (neg_calc),
        .prod_fix  (prod_fix)
    );

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        neg_d      = neg_q;
        start      = 1'b0;
        op_live    = op_valid && (op != MDU_NONE);
        busy_stall = op_live && (state_q == S_BUSY);
        accept     = op_live && !busy_stall && !ext_stall;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        MULT, MULTU: begin
                            start   = 1'b1;
                            neg_d   = neg_calc;
                            state_d = S_BUSY;
                        end
                        MTHI:    hi_d = rs_val;
                        MTLO:    lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            // Finish is a single-cycle pulse that ignores stalls, so commit must too.
            S_BUSY: begin
                if (mul_finish) begin
                    {hi_d, lo_d} = prod_fix;
                    state_d      = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        mf_sel = '0;
        if (op_valid && (state_q == S_IDLE)) begin
            if (op == MFHI)      mf_sel = hi_q;
            else if (op == MFLO) mf_sel = lo_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held.
    assign stall_req     = busy_stall & reset;
    assign mul_start     = start & reset;
    assign mul_a         = (start & reset) ? abs_a : '0;
    assign mul_b         = (start & reset) ? abs_b : '0;
    assign mul_cpu_stall = ext_stall & reset;
    assign mf_data       = mf_sel;
    assign hi            = hi_q;
    assign lo            = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit with a behavioural 32-cycle multiplier beside it.
module tb_hilo_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        ext_stall = 1'b0;
    logic        stall_req, mul_start, mul_cpu_stall;
    logic [31:0] mf_data, hi, lo, mul_a, mul_b;
    logic [63:0] mul_z;
    logic        mul_busy, mul_finish;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hilo_unit dut (
        .clk           (clk),
        .reset         (reset),
        .op_valid      (op_valid),
        .op            (op),
        .rs_val        (rs_val),
        .rt_val        (rt_val),
        .ext_stall     (ext_stall),
        .stall_req     (stall_req),
        .mf_data       (mf_data),
        .hi            (hi),
        .lo            (lo),
        .mul_start     (mul_start),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_cpu_stall (mul_cpu_stall),
        .mul_z         (mul_z),
        .mul_busy      (mul_busy),
        .mul_finish    (mul_finish)
    );

    // Multiplier stand-in: 32 unstalled edges after start, then a one-cycle finish pulse.
    logic [5:0]  m_cnt;
    logic [31:0] m_a, m_b;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_busy <= 1'b0; mul_finish <= 1'b0; m_cnt <= '0; mul_z <= '0; m_a <= '0; m_b <= '0;
        end else if (mul_start) begin
            mul_busy <= 1'b1; mul_finish <= 1'b0; m_cnt <= '0; m_a <= mul_a; m_b <= mul_b;
        end else if (mul_finish) begin
            mul_finish <= 1'b0; mul_busy <= 1'b0;
        end else if (mul_busy && !mul_cpu_stall) begin
            m_cnt <= m_cnt + 6'd1;
            if (m_cnt == 6'd31) begin
                mul_finish <= 1'b1;
                mul_z <= {32'd0, m_a} * {32'd0, m_b};
            end
        end
    end

    function automatic logic [63:0] ref_product(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (o == MULT) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [31:0] ref_operand(input logic [2:0] o, input logic [31:0] v);
        if (o == MULT && $signed(v) < 0) return 32'(-longint'($signed(v)));
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; op_valid = 1'b1; op = MULT; rs_val = 32'hFFFF_FFFD; rt_val = 32'd5;
        step(); step();
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo: got %h expected 0", lo); end
        checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b expected 0", mul_start); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
        op = MFHI; #1;
        checks++; if (mf_data !== 32'd0) begin failures++; $display("FAIL reset_mf: got %h expected 0", mf_data); end
        op_valid = 1'b0; op = MDU_NONE;
        step(); reset = 1'b1; step();
    endtask

    task automatic test_mult_vectors();
        logic [2:0]  v_op[$];
        logic [31:0] v_a[$], v_b[$];
        logic [63:0] exp_p;
        int fin;
        v_op.push_back(MULTU); v_a.push_back(32'hFFFF_FFFF); v_b.push_back(32'hFFFF_FFFF);
        v_op.push_back(MULT);  v_a.push_back(32'hFFFF_FFFD); v_b.push_back(32'd5);
        v_op.push_back(MULT);  v_a.push_back(32'h8000_0000); v_b.push_back(32'h8000_0000);
        v_op.push_back(MULT);  v_a.push_back(32'd7);         v_b.push_back(32'hFFFF_FFF0);
        for (int i = 0; i < 6; i++) begin
            v_op.push_back(($urandom_range(0, 1) == 0) ? MULT : MULTU);
            v_a.push_back($urandom()); v_b.push_back($urandom());
        end
        foreach (v_op[i]) begin
            exp_p = ref_product(v_op[i], v_a[i], v_b[i]);
            op_valid = 1'b1; op = v_op[i]; rs_val = v_a[i]; rt_val = v_b[i]; #1;
            checks++; if (mul_start !== 1'b1) begin failures++; $display("FAIL mult_start[%0d]: got %b expected 1", i, mul_start); end
            checks++; if (mul_a !== ref_operand(v_op[i], v_a[i])) begin failures++; $display("FAIL mult_a[%0d]: got %h expected %h", i, mul_a, ref_operand(v_op[i], v_a[i])); end
            checks++; if (mul_b !== ref_operand(v_op[i], v_b[i])) begin failures++; $display("FAIL mult_b[%0d]: got %h expected %h", i, mul_b, ref_operand(v_op[i], v_b[i])); end
            step(); op_valid = 1'b0; op = MDU_NONE;
            fin = 0;
            for (int c = 1; c <= 60 && fin == 0; c++) begin
                #1;
                if (mul_finish) fin = c; else step();
            end
            checks++; if (fin != 33) begin failures++; $display("FAIL mult_finish_cycle[%0d]: got %0d expected 33", i, fin); end
            step(); op_valid = 1'b1; op = MFHI; #1;
            checks++; if (mf_data !== exp_p[63:32]) begin failures++; $display("FAIL mult_mfhi[%0d]: got %h expected %h", i, mf_data, exp_p[63:32]); end
            checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mult_stall34[%0d]: got %b expected 0", i, stall_req); end
            step(); op = MFLO; #1;
            checks++; if (mf_data !== exp_p[31:0]) begin failures++; $display("FAIL mult_mflo[%0d]: got %h expected %h", i, mf_data, exp_p[31:0]); end
            checks++; if ({hi, lo} !== exp_p) begin failures++; $display("FAIL mult_hilo[%0d]: got %h expected %h", i, {hi, lo}, exp_p); end
            $display("txn op=%0d a=%h b=%h hi=%h lo=%h", v_op[i], v_a[i], v_b[i], hi, lo);
            step(); op_valid = 1'b0; op = MDU_NONE;
        end
    endtask

    task automatic test_mf_stall();
        op_valid = 1'b1; op = MULTU; rs_val = 32'd7; rt_val = 32'd6; #1;
        step(); op = MFLO; rs_val = '0; rt_val = '0; #1;
        for (int c = 1; c <= 33; c++) begin
            checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL mf_stall_c%0d: got %b expected 1", c, stall_req); end
            checks++; if (mf_data !== 32'd0) begin failures++; $display("FAIL mf_busy_data_c%0d: got %h expected 0", c, mf_data); end
            step();
        end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mf_stall_c34: got %b expected 0", stall_req); end
        checks++; if (mf_data !== 32'd42) begin failures++; $display("FAIL mf_data_c34: got %h expected 2a", mf_data); end
        $display("txn MULTU 7x6 then MFLO mf_data=%0d", mf_data);
        step(); op_valid = 1'b0; op = MDU_NONE;
    endtask

    task automatic test_ext_stall();
        logic [31:0] a, b, old_hi, old_lo;
        logic [63:0] exp_p;
        int fin;
        old_hi = hi; old_lo = lo;
        a = $urandom(); b = $urandom(); exp_p = {32'd0, a} * {32'd0, b};
        op_valid = 1'b1; op = MULTU; rs_val = a; rt_val = b; #1;
        step(); op_valid = 1'b0; op = MDU_NONE;
        fin = 0;
        for (int c = 1; c <= 80 && fin == 0; c++) begin
            ext_stall = (c >= 10 && c <= 14); #1;
            if (c == 12) begin
                checks++; if (mul_cpu_stall !== 1'b1) begin failures++; $display("FAIL cpu_stall_follow: got %b expected 1", mul_cpu_stall); end
            end
            if (mul_finish) fin = c; else step();
        end
        checks++; if (fin != 38) begin failures++; $display("FAIL stall5_finish_cycle: got %0d expected 38", fin); end
        checks++; if ({hi, lo} !== {old_hi, old_lo}) begin failures++; $display("FAIL stall5_early_commit: got %h expected %h", {hi, lo}, {old_hi, old_lo}); end
        step(); #1;
        checks++; if ({hi, lo} !== exp_p) begin failures++; $display("FAIL stall5_commit: got %h expected %h", {hi, lo}, exp_p); end
        $display("txn MULTU stalled5 a=%h b=%h hi=%h lo=%h", a, b, hi, lo);

        a = $urandom(); b = $urandom(); exp_p = ref_product(MULT, a, b);
        step(); op_valid = 1'b1; op = MULT; rs_val = a; rt_val = b; #1;
        step(); op_valid = 1'b0; op = MDU_NONE;
        fin = 0;
        for (int c = 1; c <= 80 && fin == 0; c++) begin
            ext_stall = (c == 33); #1;
            if (mul_finish) fin = c; else step();
        end
        checks++; if (fin != 33) begin failures++; $display("FAIL finstall_cycle: got %0d expected 33", fin); end
        step(); ext_stall = 1'b0; #1;
        checks++; if ({hi, lo} !== exp_p) begin failures++; $display("FAIL finstall_commit: got %h expected %h", {hi, lo}, exp_p); end
        $display("txn MULT stall-on-finish a=%h b=%h hi=%h lo=%h", a, b, hi, lo);
        step();
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v, w, x, a, b, old_hi;
        logic [63:0] exp_p;
        v = $urandom(); w = $urandom(); x = $urandom();
        op_valid = 1'b1; op = MTHI; rs_val = 32'h1234_5678; #1;
        checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL mthi_start: got %b expected 0", mul_start); end
        step(); op = MFHI; #1;
        checks++; if (mf_data !== 32'h1234_5678) begin failures++; $display("FAIL mthi_mfhi: got %h expected 12345678", mf_data); end
        step(); op = MTLO; rs_val = w; #1;
        step(); op = MFLO; #1;
        checks++; if (mf_data !== w) begin failures++; $display("FAIL mtlo_mflo: got %h expected %h", mf_data, w); end
        step(); op = MTHI; rs_val = v; ext_stall = 1'b1; #1;
        step(); ext_stall = 1'b0; op_valid = 1'b0; #1;
        checks++; if (hi !== 32'h1234_5678) begin failures++; $display("FAIL mthi_ext_stall: got %h expected 12345678", hi); end
        $display("txn MTHI/MTLO hi=%h lo=%h", hi, lo);

        old_hi = hi; a = $urandom(); b = $urandom(); exp_p = {32'd0, a} * {32'd0, b};
        op_valid = 1'b1; op = MULTU; rs_val = a; rt_val = b; #1;
        step(); op = MTLO; rs_val = x; rt_val = '0; #1;
        checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL mtlo_busy_start: got %b expected 0", mul_start); end
        for (int c = 1; c <= 33; c++) begin
            checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL mtlo_busy_stall_c%0d: got %b expected 1", c, stall_req); end
            checks++; if (lo !== w || hi !== old_hi) begin failures++; $display("FAIL mtlo_busy_hold_c%0d: got %h expected %h", c, {hi, lo}, {old_hi, w}); end
            step();
        end
        checks++; if ({hi, lo} !== exp_p) begin failures++; $display("FAIL mtlo_busy_commit: got %h expected %h", {hi, lo}, exp_p); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL mtlo_busy_release: got %b expected 0", stall_req); end
        step(); op_valid = 1'b0; op = MDU_NONE; #1;
        checks++; if (lo !== x || hi !== exp_p[63:32]) begin failures++; $display("FAIL mtlo_after_idle: got %h expected %h", {hi, lo}, {exp_p[63:32], x}); end
        $display("txn MTLO while busy lo=%h", lo);
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] e1, e2;
        int fin;
        a1 = $urandom(); b1 = $urandom() | 32'h8000_0000; a2 = $urandom(); b2 = $urandom();
        e1 = ref_product(MULT, a1, b1); e2 = {32'd0, a2} * {32'd0, b2};
        op_valid = 1'b1; op = MULT; rs_val = a1; rt_val = b1; #1;
        step(); op = MULTU; rs_val = a2; rt_val = b2; #1;
        for (int c = 1; c <= 33; c++) begin
            checks++; if (mul_start !== 1'b0) begin failures++; $display("FAIL b2b_start_busy_c%0d: got %b expected 0", c, mul_start); end
            step();
        end
        checks++; if (mul_start !== 1'b1) begin failures++; $display("FAIL b2b_start_c34: got %b expected 1", mul_start); end
        checks++; if (mul_a !== a2) begin failures++; $display("FAIL b2b_mul_a: got %h expected %h", mul_a, a2); end
        checks++; if ({hi, lo} !== e1) begin failures++; $display("FAIL b2b_first: got %h expected %h", {hi, lo}, e1); end
        step(); op_valid = 1'b0; op = MDU_NONE;
        fin = 0;
        for (int c = 1; c <= 60 && fin == 0; c++) begin
            #1;
            if (mul_finish) fin = c; else step();
        end
        checks++; if (fin != 33) begin failures++; $display("FAIL b2b_finish_cycle: got %0d expected 33", fin); end
        step(); #1;
        checks++; if ({hi, lo} !== e2) begin failures++; $display("FAIL b2b_second: got %h expected %h", {hi, lo}, e2); end
        $display("txn back-to-back first=%h second=%h", e1, e2);
        step();
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op = MTHI; rs_val = 32'hA5A5_A5A5; #1;
        step(); op = MTLO; rs_val = 32'h5A5A_5A5A; #1;
        step(); op = MULT; rs_val = $urandom(); rt_val = $urandom(); #1;
        step(); op = MFHI;
        for (int c = 1; c <= 14; c++) step();
        #2; reset = 1'b0; #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin failures++; $display("FAIL midreset_hilo: got %h expected 0", {hi, lo}); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL midreset_stall: got %b expected 0", stall_req); end
        checks++; if (mf_data !== 32'd0) begin failures++; $display("FAIL midreset_mf: got %h expected 0", mf_data); end
        step(); step(); reset = 1'b1; #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL midreset_idle: got %b expected 0", stall_req); end
        op_valid = 1'b0; op = MDU_NONE;
        for (int c = 0; c < 50; c++) step();
        checks++; if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL midreset_late_commit: got %h expected 0", {hi, lo}); end
        $display("txn reset mid-MULT hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset();
        test_mult_vectors();
        test_mf_stall();
        test_ext_stall();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
